display_source_sequencer: RTL and testbench
===========================================

// Module: display_source_sequencer
// PURPOSE
//  Parametrised, registered successor to the 7-seg source mux. Selects one of NUM_CH
//  DATA_W-bit measurement channels (PWM, R2R, XADC, SAR, ...) for the display driver.
//  Selection comes from a direct load, up/down steps or an auto-scan timer.
//  Each channel has its own decimal-point mask. Output is sample-and-hold, with freeze.
// PARAMETERS
//  NUM_CH        13           number of input channels (>=2)
//  DATA_W        16           channel/output data width
//  DP_W          4            decimal-point field width (one bit per digit)
//  DWELL_CYCLES  100_000_000  auto-scan dwell per channel in clk cycles (1 s @ 100 MHz)
//  SEL_W         $clog2(NUM_CH)  select width (derived; not to be overridden)
// PORTS
//  clk            in   1               system clock
//  reset          in   1               synchronous, active-high reset
//  mode_auto      in   1               1 = auto-scan, 0 = manual
//  step_up        in   1               1-cycle pulse (debounced upstream): next channel
//  step_dn        in   1               1-cycle pulse: previous channel
//  sel_load       in   1               1-cycle pulse: load sel_direct
//  sel_direct     in   SEL_W           direct channel index
//  freeze         in   1               1 = hold out/decimal_pt
//  ch_data        in   NUM_CH*DATA_W   packed channel data; ch k at [k*DATA_W +: DATA_W]
//  ch_valid       in   NUM_CH          per-channel new-sample strobe
//  dp_mask        in   NUM_CH*DP_W     per-channel decimal-point pattern
//  out            out  DATA_W          displayed value (registered)
//  decimal_pt     out  DP_W            decimal-point control (registered)
//  cur_sel        out  SEL_W           active channel index
//  out_valid      out  1               1 once the active channel has been captured
//  sel_changed    out  1               1-cycle pulse when cur_sel changes
//  sel_err        out  1               1-cycle pulse: sel_load with sel_direct >= NUM_CH
// BEHAVIOUR
//  Reset: cur_sel=0, out=0, decimal_pt=0, out_valid=0, sel_changed=0, sel_err=0, dwell=0.
//  Select update, one per cycle, priority: sel_load > (step_up ^ step_dn) > auto terminal count.
//   - sel_load, in range: cur_sel <= sel_direct. Out of range: cur_sel unchanged, sel_err=1.
//   - step_up alone: wrap NUM_CH-1 -> 0. step_dn alone: wrap 0 -> NUM_CH-1.
//   - step_up & step_dn together: cancel; no change.
//   - Auto: dwell counts 0..DWELL_CYCLES-1. At terminal count, advance +1 with wrap, dwell<=0.
//   - Any manual select event (load or step) restarts dwell at 0. Steps allowed in both modes.
//   - mode_auto 0->1: dwell restarts at 0. In manual mode dwell is held at 0.
//  sel_changed=1 in the cycle after cur_sel takes a new value only. Loading the same index is no change.
//  Capture, registered, 1-cycle latency from cur_sel:
//   - Cycle after a select change: out <= ch_data[cur_sel] and decimal_pt <= dp_mask[cur_sel],
//     unconditionally; out_valid <= 1.
//   - Otherwise out updates only when ch_valid[cur_sel]=1; other channels' strobes are ignored.
//   - decimal_pt tracks dp_mask[cur_sel] every cycle.
//   - freeze=1: out, decimal_pt and out_valid hold. Selection logic and sel_changed keep running.
//     On freeze release, the next cycle recaptures ch_data[cur_sel] unconditionally.
//  Simultaneous select change and ch_valid: the new channel's data wins.
//  Reset mid-scan: everything returns to reset values in the same edge. There is no partial state.
// STRUCTURE
//  Package disp_pkg:
//   - sel_src_e enum {SRC_NONE, SRC_LOAD, SRC_STEP, SRC_AUTO}
//   - localparams for the default NUM_CH/DATA_W/DP_W
//   - channel index constants (CH_PWM_SCALED=4, CH_R2R_SCALED=7, CH_XADC_SCALED=10, CH_SAR=11)
//  Sub-module dwell_timer: counter with clear, enable and terminal-count pulse, parametrised by DWELL_CYCLES.
//  Top level holds the select FSM/arbiter, the index mux and the capture registers.
// TESTING (bench: DWELL_CYCLES=8, NUM_CH=13)
//  1 Reset, then ch_data[0]=16'h1234 with ch_valid[0] pulse
//    -> out=0 during reset; next cycle after valid, out=16'h1234, out_valid=1.
//  2 Manual step_up x13 from 0 -> cur_sel visits 1..12 then 0.
//    sel_changed pulses 13x. step_dn at 0 -> 12.
//  3 sel_load with 5 -> cur_sel=5, out=ch_data[5] the next cycle.
//    sel_load with 13 -> sel_err=1, cur_sel stays 5.
//    step_up & step_dn together -> no change.
//  4 mode_auto=1 -> cur_sel advances every 8 cycles with wrap 12->0.
//    step_up at dwell=5 -> immediate advance, and the next auto advance comes 8 cycles later.
//  5 Select ch4 with dp_mask[4]=4'b1000 -> decimal_pt=4'b1000.
//    freeze=1, then change ch_data[4] and pulse ch_valid[4] -> out unchanged.
//    Release freeze -> out = new value in 1 cycle.
//  6 Auto scan at cur_sel=9 with reset asserted -> the next edge gives cur_sel=0, out=0,
//    out_valid=0, dwell=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display source sequencer.
// Covers the select-source tags, default geometry and the well-known channel indices.
package disp_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_STEP = 2'd2,
    SRC_AUTO = 2'd3
  } sel_src_e;

  localparam int DEF_NUM_CH = 13;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DP_W   = 4;

  localparam int CH_PWM_SCALED  = 4;
  localparam int CH_R2R_SCALED  = 7;
  localparam int CH_XADC_SCALED = 10;
  localparam int CH_SAR         = 11;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    if (modulus > 1) begin
      return $clog2(modulus);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Auto-scan dwell counter: counts 0..DWELL_CYCLES-1 while enabled and flags the last count.
// Clear wins over counting so any manual select event restarts the dwell window.
module dwell_timer
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int CNT_W        = cnt_width(DWELL_CYCLES)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  assign w_tc = i_en && (r_count == LP_LAST);
  assign o_tc = w_tc;

  // Dwell count register; wraps to zero on the terminal count.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= LP_ZERO;
    end else if (w_tc) begin
      r_count <= LP_ZERO;
    end else if (i_en) begin
      r_count <= r_count + LP_ONE;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/display_source_sequencer.sv
// Registered channel selector for the display driver: load/step/auto-scan select,
// per-channel decimal-point mask, sample-and-hold output with freeze.
module display_source_sequencer
  import disp_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DP_W         = DEF_DP_W,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int SEL_W        = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_mode_auto,
  input  logic                     i_step_up,
  input  logic                     i_step_dn,
  input  logic                     i_sel_load,
  input  logic [SEL_W-1:0]         i_sel_direct,
  input  logic                     i_freeze,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  input  logic [NUM_CH-1:0]        i_ch_valid,
  input  logic [NUM_CH*DP_W-1:0]   i_dp_mask,
  output logic [DATA_W-1:0]        o_out,
  output logic [DP_W-1:0]          o_decimal_pt,
  output logic [SEL_W-1:0]         o_cur_sel,
  output logic                     o_out_valid,
  output logic                     o_sel_changed,
  output logic                     o_sel_err
);

  localparam logic [SEL_W-1:0] LP_SEL_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] LP_SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] LP_SEL_LAST = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]   LP_NUM_CH_X = (SEL_W + 1)'(NUM_CH);

  logic [SEL_W-1:0]  r_cur_sel;
  logic              r_sel_changed;
  logic              r_sel_err;
  logic              r_freeze_d;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out;
  logic [DP_W-1:0]   r_decimal_pt;

  sel_src_e          w_src;
  logic              w_tc;
  logic              w_manual;
  logic              w_load_ok;
  logic [SEL_W-1:0]  w_sel_inc;
  logic [SEL_W-1:0]  w_sel_dec;
  logic [SEL_W-1:0]  w_next_sel;
  logic [DATA_W-1:0] w_data;
  logic [DP_W-1:0]   w_dp;
  logic              w_valid;
  logic              w_recapture;

  assign w_manual  = i_sel_load | (i_step_up ^ i_step_dn);
  assign w_load_ok = ({1'b0, i_sel_direct} < LP_NUM_CH_X);
  assign w_sel_inc = (r_cur_sel == LP_SEL_LAST) ? LP_SEL_ZERO : (r_cur_sel + LP_SEL_ONE);
  assign w_sel_dec = (r_cur_sel == LP_SEL_ZERO) ? LP_SEL_LAST : (r_cur_sel - LP_SEL_ONE);

  // Dwell is held at zero in manual mode, so entering auto always starts a fresh window.
  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_manual | ~i_mode_auto),
    .i_en    (i_mode_auto),
    .o_tc    (w_tc)
  );

  // Select-source arbitration: load, then a lone step, then the auto terminal count.
  always_comb begin
    w_src = SRC_NONE;
    if (i_sel_load) begin
      w_src = SRC_LOAD;
    end else if (i_step_up ^ i_step_dn) begin
      w_src = SRC_STEP;
    end else if (w_tc) begin
      w_src = SRC_AUTO;
    end else begin
      w_src = SRC_NONE;
    end
  end

  // Next channel index for the winning source.
  always_comb begin
    w_next_sel = r_cur_sel;
    case (w_src)
      SRC_LOAD: w_next_sel = w_load_ok ? i_sel_direct : r_cur_sel;
      SRC_STEP: w_next_sel = i_step_up ? w_sel_inc : w_sel_dec;
      SRC_AUTO: w_next_sel = w_sel_inc;
      default:  w_next_sel = r_cur_sel;
    endcase
  end

  // One-hot AND-OR mux of the active channel's data, mask and strobe.
  always_comb begin
    w_data  = {DATA_W{1'b0}};
    w_dp    = {DP_W{1'b0}};
    w_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_data  = w_data  | (i_ch_data[k*DATA_W +: DATA_W] & {DATA_W{r_cur_sel == SEL_W'(k)}});
      w_dp    = w_dp    | (i_dp_mask[k*DP_W +: DP_W]     & {DP_W{r_cur_sel == SEL_W'(k)}});
      w_valid = w_valid | (i_ch_valid[k] & (r_cur_sel == SEL_W'(k)));
    end
  end

  // A fresh selection or a freeze release forces a capture regardless of the strobe.
  assign w_recapture = r_sel_changed | r_freeze_d;

  // Selection state and capture registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cur_sel     <= LP_SEL_ZERO;
      r_sel_changed <= 1'b0;
      r_sel_err     <= 1'b0;
      r_freeze_d    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out         <= {DATA_W{1'b0}};
      r_decimal_pt  <= {DP_W{1'b0}};
    end else begin
      r_cur_sel     <= w_next_sel;
      r_sel_changed <= (w_next_sel != r_cur_sel);
      r_sel_err     <= i_sel_load & ~w_load_ok;
      r_freeze_d    <= i_freeze;
      if (!i_freeze) begin
        r_decimal_pt <= w_dp;
        if (w_recapture || w_valid) begin
          r_out       <= w_data;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign o_out         = r_out;
  assign o_decimal_pt  = r_decimal_pt;
  assign o_cur_sel     = r_cur_sel;
  assign o_out_valid   = r_out_valid;
  assign o_sel_changed = r_sel_changed;
  assign o_sel_err     = r_sel_err;

endmodule

// File: tb/tb_display_source_sequencer.sv
// Directed bench for display_source_sequencer with a cycle-level reference model
// and a per-cycle compare process, plus hand-computed checkpoints.
module tb_display_source_sequencer;

  localparam int NUM_CH = 13;
  localparam int DATA_W = 16;
  localparam int DP_W   = 4;
  localparam int DWELL  = 8;
  localparam int SEL_W  = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     mode_auto;
  logic                     step_up;
  logic                     step_dn;
  logic                     sel_load;
  logic [SEL_W-1:0]         sel_direct;
  logic                     freeze;
  logic [NUM_CH*DATA_W-1:0] ch_data_p;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DP_W-1:0]   dp_p;
  logic [DATA_W-1:0]        out;
  logic [DP_W-1:0]          decimal_pt;
  logic [SEL_W-1:0]         cur_sel;
  logic                     out_valid;
  logic                     sel_changed;
  logic                     sel_err;

  logic [DATA_W-1:0] chd [NUM_CH];
  logic [DP_W-1:0]   dpm [NUM_CH];

  int n_cmp = 0;
  int n_fail = 0;
  int n_chg = 0;
  int base_chg;

  // reference model state
  logic              m_live = 1'b0;
  int                m_sel, m_dwell;
  logic [DATA_W-1:0] m_out;
  logic [DP_W-1:0]   m_dp;
  logic              m_valid, m_chg, m_err, m_frz;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data_p[k*DATA_W +: DATA_W] = chd[k];
      dp_p[k*DP_W +: DP_W]          = dpm[k];
    end
  end

  display_source_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DP_W(DP_W), .DWELL_CYCLES(DWELL)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_mode_auto(mode_auto), .i_step_up(step_up),
    .i_step_dn(step_dn), .i_sel_load(sel_load), .i_sel_direct(sel_direct),
    .i_freeze(freeze), .i_ch_data(ch_data_p), .i_ch_valid(ch_valid), .i_dp_mask(dp_p),
    .o_out(out), .o_decimal_pt(decimal_pt), .o_cur_sel(cur_sel), .o_out_valid(out_valid),
    .o_sel_changed(sel_changed), .o_sel_err(sel_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int f_next_sel(int s, int dw, logic ld, logic [SEL_W-1:0] d,
                                    logic up, logic dn, logic au);
    if (ld) return (int'(d) < NUM_CH) ? int'(d) : s;
    if (up && !dn) return (s + 1) % NUM_CH;
    if (dn && !up) return (s + NUM_CH - 1) % NUM_CH;
    if (au && dw == DWELL - 1) return (s + 1) % NUM_CH;
    return s;
  endfunction

  function automatic int f_next_dwell(int dw, logic ld, logic up, logic dn, logic au);
    if (!au || ld || (up ^ dn)) return 0;
    return (dw + 1) % DWELL;
  endfunction

  // Reference model: outputs follow from the behavioural rules applied once per edge.
  always @(posedge clk) begin
    m_live <= 1'b1;
    if (reset) begin
      m_sel <= 0; m_dwell <= 0; m_out <= '0; m_dp <= '0;
      m_valid <= 1'b0; m_chg <= 1'b0; m_err <= 1'b0; m_frz <= 1'b0;
    end else begin
      m_sel   <= f_next_sel(m_sel, m_dwell, sel_load, sel_direct, step_up, step_dn, mode_auto);
      m_chg   <= f_next_sel(m_sel, m_dwell, sel_load, sel_direct, step_up, step_dn, mode_auto) != m_sel;
      m_dwell <= f_next_dwell(m_dwell, sel_load, step_up, step_dn, mode_auto);
      m_err   <= sel_load && (int'(sel_direct) >= NUM_CH);
      m_frz   <= freeze;
      if (!freeze) begin
        m_dp <= dpm[m_sel];
        if (m_chg || m_frz || ch_valid[m_sel]) begin
          m_out   <= chd[m_sel];
          m_valid <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("out", 32'(out), 32'(m_out));
      chk("decimal_pt", 32'(decimal_pt), 32'(m_dp));
      chk("cur_sel", 32'(cur_sel), 32'(m_sel));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("sel_changed", 32'(sel_changed), 32'(m_chg));
      chk("sel_err", 32'(sel_err), 32'(m_err));
      if (sel_changed) n_chg++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mode_auto = 1'b0; step_up = 1'b0; step_dn = 1'b0;
    sel_load = 1'b0; sel_direct = 4'd0; freeze = 1'b0; ch_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      chd[k] = 16'hA000 + 16'(k) * 16'h0101;
      dpm[k] = 4'(k) ^ 4'b0101;
    end
    dpm[4] = 4'b1000;

    // 1: reset, then a strobe on channel 0
    repeat (3) step();
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sel", 32'(cur_sel), 32'h0);
    chd[0] = 16'h1234;
    reset = 1'b0;
    step();
    chk("pre_strobe_out", 32'(out), 32'h0);
    ch_valid = 13'b1;
    step();
    ch_valid = '0;
    chk("strobe_out", 32'(out), 32'h1234);
    chk("strobe_valid", 32'(out_valid), 32'h1);

    // 2: thirteen steps up wrap back to 0; step down from 0 wraps to 12
    base_chg = n_chg;
    for (int i = 1; i <= NUM_CH; i++) begin
      step_up = 1'b1;
      step();
      chk("step_up_sel", 32'(cur_sel), 32'(i % NUM_CH));
    end
    step_up = 1'b0;
    step();
    chk("sel_changed_count", 32'(n_chg - base_chg), 32'd13);
    step_dn = 1'b1;
    step();
    step_dn = 1'b0;
    chk("step_dn_wrap", 32'(cur_sel), 32'd12);
    step();
    chk("out_ch12", 32'(out), 32'hAC0C);

    // 3: direct load, out-of-range load, cancelled steps
    sel_direct = 4'd5; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    chk("load5_sel", 32'(cur_sel), 32'd5);
    step();
    chk("load5_out", 32'(out), 32'hA505);
    sel_direct = 4'd13; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    chk("load13_err", 32'(sel_err), 32'h1);
    chk("load13_sel", 32'(cur_sel), 32'd5);
    step();
    chk("err_pulse_end", 32'(sel_err), 32'h0);
    step_up = 1'b1; step_dn = 1'b1;
    step();
    step_up = 1'b0; step_dn = 1'b0;
    chk("cancel_sel", 32'(cur_sel), 32'd5);
    chk("cancel_chg", 32'(sel_changed), 32'h0);
    step();

    // 4: auto scan every 8 cycles, wrap, step restarting the dwell
    mode_auto = 1'b1;
    repeat (7) step();
    chk("auto_hold", 32'(cur_sel), 32'd5);
    step();
    chk("auto_adv", 32'(cur_sel), 32'd6);
    repeat (56) step();
    chk("auto_wrap", 32'(cur_sel), 32'd0);
    repeat (5) step();
    step_up = 1'b1;
    step();
    step_up = 1'b0;
    chk("auto_step", 32'(cur_sel), 32'd1);
    repeat (7) step();
    chk("dwell_restart_hold", 32'(cur_sel), 32'd1);
    step();
    chk("dwell_restart_adv", 32'(cur_sel), 32'd2);
    mode_auto = 1'b0;

    // 5: decimal point and freeze
    sel_direct = 4'd4; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    step();
    chk("dp_ch4", 32'(decimal_pt), 32'h8);
    chk("out_ch4", 32'(out), 32'hA404);
    freeze = 1'b1;
    step();
    chd[4] = 16'hBEEF; ch_valid = 13'b1 << 4;
    step();
    ch_valid = '0;
    step();
    chk("frozen_out", 32'(out), 32'hA404);
    freeze = 1'b0;
    step();
    chk("release_out", 32'(out), 32'hBEEF);

    // 6: reset in the middle of an auto scan
    mode_auto = 1'b1; sel_direct = 4'd9; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    chk("scan9_sel", 32'(cur_sel), 32'd9);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midrst_sel", 32'(cur_sel), 32'd0);
    chk("midrst_out", 32'(out), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;
    repeat (7) step();
    chk("midrst_dwell_hold", 32'(cur_sel), 32'd0);
    step();
    chk("midrst_dwell_adv", 32'(cur_sel), 32'd1);
    mode_auto = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
